// File: rtl/wf_pixel_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : wf_pixel_pkg
// Purpose : Shared constants and types for the pixel loader: serial frame
//           length, opcode values, pixel RAM widths and FSM state encodings.
// Revision: 1.0 - initial release
// ============================================================================
package wf_pixel_pkg;

    localparam int FRAME_BITS = 24;
    localparam int ADDR_W     = 6;
    localparam int PIX_W      = 16;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wf_pixel_loader_serial_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : WF_serial_rx
// Purpose : Receives 24-bit MSB-first frames over an asynchronous
//           clock/data/select link. All three lines are synchronized to clk,
//           ser_clk rising edges shift data in while select is low.
// Ports   : clk, reset        - system clock, synchronous active-high reset
//           ser_clk/dat/cs_n  - asynchronous serial link from the CPU
//           frame_valid       - one-clk pulse, frame_data holds a full frame
//           frame_data        - received frame, pixel bit 15 forced to 0
//           frame_err         - one-clk pulse on a short or over-long frame
// Revision: 1.0 - initial release
// ============================================================================
module WF_serial_rx
    import wf_pixel_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ser_clk,
    input  logic                  ser_dat,
    input  logic                  ser_cs_n,
    output logic                  frame_valid,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_err
);

    localparam logic [4:0] c_last_bit = 5'(FRAME_BITS);

    logic                  r_clk_s1, r_clk_s2, r_clk_d;
    logic                  r_dat_s1, r_dat_s2;
    logic                  r_cs_s1,  r_cs_s2,  r_cs_d;
    logic [4:0]            r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_extra;
    logic                  r_valid;
    logic                  r_err;

    logic w_clk_rise, w_cs_fall, w_cs_rise;

    assign w_clk_rise = r_clk_s2 & ~r_clk_d;
    assign w_cs_fall  = ~r_cs_s2 & r_cs_d;
    assign w_cs_rise  = r_cs_s2 & ~r_cs_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1  <= 1'b0;
            r_clk_s2  <= 1'b0;
            r_clk_d   <= 1'b0;
            r_dat_s1  <= 1'b0;
            r_dat_s2  <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_d    <= 1'b1;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_extra   <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_clk_s1 <= ser_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= ser_dat;
            r_dat_s2 <= r_dat_s1;
            r_cs_s1  <= ser_cs_n;
            r_cs_s2  <= r_cs_s1;
            r_cs_d   <= r_cs_s2;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;

            if (w_cs_fall) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_extra   <= 1'b0;
            end else if (w_cs_rise) begin
                // A partial frame, or bits beyond a completed frame, is an error.
                // A completed frame was already handed over and stays valid.
                if (r_extra || (r_bit_cnt != 5'd0 && r_bit_cnt != c_last_bit))
                    r_err <= 1'b1;
                r_bit_cnt <= '0;
                r_extra   <= 1'b0;
            end else if (w_clk_rise && !r_cs_s2) begin
                if (r_bit_cnt == c_last_bit) begin
                    r_extra <= 1'b1;
                end else begin
                    r_shift   <= {r_shift[FRAME_BITS-2:0], r_dat_s2};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                    if (r_bit_cnt == c_last_bit - 5'd1)
                        r_valid <= 1'b1;
                end
            end
        end
    end

    assign frame_valid = r_valid;
    assign frame_data  = {r_shift[23:16], 1'b0, r_shift[14:0]};
    assign frame_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/wf_pixel_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : wf_pixel_loader
// Purpose : Accepts serial pixel frames from the CPU, holds one pending frame
//           and writes the pixel RAM only while the display write window is
//           open (between scan_done and the next scan_en). Supports single
//           pixel writes, full-frame fill and full-frame clear.
// Ports   : clk, reset        - system clock, synchronous active-high reset
//           ser_clk/dat/cs_n  - asynchronous serial link from the CPU
//           scan_en/scan_done - scan cycle start / row shift complete pulses
//           ram_wr_*          - registered pixel RAM write port
//           busy              - frame pending or operation in progress
//           frame_err         - one-clk pulse on a rejected frame
// Revision: 1.0 - initial release
// ============================================================================
module wf_pixel_loader
    import wf_pixel_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ser_clk,
    input  logic              ser_dat,
    input  logic              ser_cs_n,
    input  logic              scan_en,
    input  logic              scan_done,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [PIX_W-1:0]  ram_wr_pixels,
    output logic              busy,
    output logic              frame_err
);

    logic                  w_rx_valid;
    logic [FRAME_BITS-1:0] w_rx_data;
    logic                  w_rx_err;

    WF_serial_rx u_rx (
        .clk         (clk),
        .reset       (reset),
        .ser_clk     (ser_clk),
        .ser_dat     (ser_dat),
        .ser_cs_n    (ser_cs_n),
        .frame_valid (w_rx_valid),
        .frame_data  (w_rx_data),
        .frame_err   (w_rx_err)
    );

    state_t            r_state, w_state_nxt;
    logic              r_win;
    logic              r_pend_full;
    logic [1:0]        r_pend_op;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [PIX_W-1:0]  r_pend_pix;
    logic [ADDR_W-1:0] r_fill_cnt, w_fill_cnt_nxt;
    logic [PIX_W-1:0]  r_fill_pix, w_fill_pix_nxt;

    logic              w_win_nxt;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [PIX_W-1:0]  w_wr_pix;
    logic              w_consume;
    logic              w_op_err;
    logic              w_overrun;

    // Write decisions look at the window value of the cycle in which the
    // registered write becomes visible, so a write never overlaps a closed
    // window. scan_en wins over scan_done.
    assign w_win_nxt = scan_en ? 1'b0 : (scan_done ? 1'b1 : r_win);
    assign w_overrun = w_rx_valid & r_pend_full;

    always_comb begin
        w_state_nxt    = r_state;
        w_wr_en        = 1'b0;
        w_wr_addr      = ram_wr_addr;
        w_wr_pix       = ram_wr_pixels;
        w_consume      = 1'b0;
        w_op_err       = 1'b0;
        w_fill_cnt_nxt = r_fill_cnt;
        w_fill_pix_nxt = r_fill_pix;

        unique case (r_state)
            ST_IDLE: begin
                if (r_pend_full && w_win_nxt) begin
                    // The pending slot is freed on decode so the CPU can queue
                    // the next frame while a fill runs.
                    w_consume = 1'b1;
                    case (r_pend_op)
                        OP_WRITE: begin
                            w_wr_en     = 1'b1;
                            w_wr_addr   = r_pend_addr;
                            w_wr_pix    = r_pend_pix;
                            w_state_nxt = ST_WRITE;
                        end
                        OP_FILL, OP_CLEAR: begin
                            w_fill_pix_nxt = (r_pend_op == OP_FILL) ? r_pend_pix : '0;
                            // Address 0 is written on decode; FILL continues at 1.
                            w_wr_en        = 1'b1;
                            w_wr_addr      = '0;
                            w_wr_pix       = w_fill_pix_nxt;
                            w_fill_cnt_nxt = 6'd1;
                            w_state_nxt    = ST_FILL;
                        end
                        OP_RSVD: begin
                            w_op_err = 1'b1;
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_FILL: begin
                if (w_win_nxt) begin
                    w_wr_en        = 1'b1;
                    w_wr_addr      = r_fill_cnt;
                    w_wr_pix       = r_fill_pix;
                    w_fill_cnt_nxt = r_fill_cnt + 6'd1;
                    if (r_fill_cnt == 6'd63)
                        w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_win         <= 1'b0;
            r_pend_full   <= 1'b0;
            r_pend_op     <= '0;
            r_pend_addr   <= '0;
            r_pend_pix    <= '0;
            r_fill_cnt    <= '0;
            r_fill_pix    <= '0;
            ram_wr_en     <= 1'b0;
            ram_wr_addr   <= '0;
            ram_wr_pixels <= '0;
            frame_err     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_win      <= w_win_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
            r_fill_pix <= w_fill_pix_nxt;

            if (w_consume) begin
                r_pend_full <= 1'b0;
            end else if (w_rx_valid && !r_pend_full) begin
                r_pend_full <= 1'b1;
                r_pend_op   <= w_rx_data[23:22];
                r_pend_addr <= w_rx_data[21:16];
                r_pend_pix  <= w_rx_data[15:0];
            end

            ram_wr_en <= w_wr_en;
            if (w_wr_en) begin
                ram_wr_addr   <= w_wr_addr;
                ram_wr_pixels <= w_wr_pix;
            end

            frame_err <= w_rx_err | w_overrun | w_op_err;
        end
    end

    assign busy = r_pend_full | (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wf_pixel_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_wf_pixel_loader
// Purpose : Self-checking bench for wf_pixel_loader: table of single-frame
//           vectors plus hand-written fill, window-gap, overrun and reset
//           sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wf_pixel_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ser_clk, ser_dat, ser_cs_n;
    logic        scan_en, scan_done;
    logic        ram_wr_en;
    logic [5:0]  ram_wr_addr;
    logic [15:0] ram_wr_pixels;
    logic        busy, frame_err;

    always #5 clk = ~clk;

    wf_pixel_loader dut (
        .clk           (clk),
        .reset         (reset),
        .ser_clk       (ser_clk),
        .ser_dat       (ser_dat),
        .ser_cs_n      (ser_cs_n),
        .scan_en       (scan_en),
        .scan_done     (scan_done),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_pixels (ram_wr_pixels),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [5:0]  q_addr[$];
    logic [15:0] q_pix[$];
    logic        q_busy[$];
    time         t_first_wr;
    time         t_rise24;
    int          err_cnt = 0;

    // Write / error monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (ram_wr_en) begin
            if (q_addr.size() == 0) t_first_wr = $time;
            q_addr.push_back(ram_wr_addr);
            q_pix.push_back(ram_wr_pixels);
            q_busy.push_back(busy);
        end
        if (frame_err) err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_pix.delete();
        q_busy.delete();
        err_cnt = 0;
    endtask

    task automatic send_frame(input logic [23:0] frame, input int nbits);
        @(negedge clk);
        ser_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ser_dat = (i < 24) ? frame[23-i] : 1'b0;
            ser_clk = 1'b0;
            repeat (4) @(negedge clk);
            ser_clk = 1'b1;
            if (i == 23) t_rise24 = $time;
            repeat (4) @(negedge clk);
        end
        ser_clk = 1'b0;
        repeat (4) @(negedge clk);
        ser_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse(input logic en, input logic done);
        scan_en   = en;
        scan_done = done;
        @(posedge clk);
        #1;
        scan_en   = 1'b0;
        scan_done = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int limit, input string name);
        int k = 0;
        while (q_addr.size() < n && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, 32'(q_addr.size() >= n), 32'd1);
    endtask

    task automatic check_fill(input string name, input logic [15:0] pix);
        int bad = 0;
        check({name, " count"}, 32'(q_addr.size()), 32'd64);
        foreach (q_addr[i]) begin
            if (q_addr[i] != 6'(i) || q_pix[i] != pix) bad++;
        end
        check({name, " sequence"}, 32'(bad), 32'd0);
    endtask

    typedef struct {
        logic [23:0] frame;
        int          nbits;
        int          exp_wr;
        logic [5:0]  exp_addr;
        logic [15:0] exp_pix;
        int          exp_err;
    } vec_t;

    vec_t vecs[9];
    int   n_at_reset;

    initial begin
        vecs[0] = '{24'h05_7C1F, 24, 1, 6'd5,  16'h7C1F, 0};
        vecs[1] = '{24'h3F_FFFF, 24, 1, 6'd63, 16'h7FFF, 0};
        vecs[2] = '{24'h2A_1234, 24, 1, 6'd42, 16'h1234, 0};
        vecs[3] = '{24'h10_8000, 24, 1, 6'd16, 16'h0000, 0};
        vecs[4] = '{24'hC0_0000, 24, 0, 6'd0,  16'h0000, 1};
        vecs[5] = '{24'hC0_0000, 10, 0, 6'd0,  16'h0000, 1};
        vecs[6] = '{24'h05_7C1F, 23, 0, 6'd0,  16'h0000, 1};
        vecs[7] = '{24'h05_7C1F, 1,  0, 6'd0,  16'h0000, 1};
        vecs[8] = '{24'h21_5555, 25, 1, 6'd33, 16'h5555, 1};

        reset = 1'b1; ser_clk = 1'b0; ser_dat = 1'b0; ser_cs_n = 1'b1;
        scan_en = 1'b0; scan_done = 1'b0;
        repeat (4) @(negedge clk);
        check("reset wr_en",  32'(ram_wr_en),     32'd0);
        check("reset addr",   32'(ram_wr_addr),   32'd0);
        check("reset pixels", 32'(ram_wr_pixels), 32'd0);
        check("reset busy",   32'(busy),          32'd0);
        check("reset err",    32'(frame_err),     32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset wr_en", 32'(ram_wr_en), 32'd0);

        pulse(1'b0, 1'b1);

        for (int v = 0; v < 9; v++) begin
            clear_log();
            send_frame(vecs[v].frame, vecs[v].nbits);
            repeat (4) @(negedge clk);
            #1;
            check($sformatf("vec%0d writes", v), 32'(q_addr.size()), 32'(vecs[v].exp_wr));
            if (vecs[v].exp_wr == 1 && q_addr.size() > 0) begin
                check($sformatf("vec%0d addr", v), 32'(q_addr[0]), 32'(vecs[v].exp_addr));
                check($sformatf("vec%0d pixel", v), 32'(q_pix[0]), 32'(vecs[v].exp_pix));
                check($sformatf("vec%0d latency", v), 32'((t_first_wr - t_rise24) / 10), 32'd5);
            end
            check($sformatf("vec%0d frame_err", v), 32'(err_cnt), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d busy", v), 32'(busy), 32'd0);
        end

        // Fill with window open throughout.
        clear_log();
        send_frame(24'h40_03E0, 24);
        wait_writes(64, 200, "fill done");
        @(negedge clk);
        #1;
        check_fill("fill", 16'h03E0);
        if (q_busy.size() == 64) begin
            check("fill busy before last", 32'(q_busy[62]), 32'd1);
            check("fill busy at last",     32'(q_busy[63]), 32'd0);
        end
        check("fill busy after", 32'(busy), 32'd0);

        // Clear opcode.
        clear_log();
        send_frame(24'h80_1234, 24);
        wait_writes(64, 200, "clear done");
        @(negedge clk);
        check_fill("clear", 16'h0000);

        // Fill interrupted by a closed window after address 20.
        clear_log();
        send_frame(24'h40_001F, 24);
        wait_writes(21, 200, "gap reach 20");
        pulse(1'b1, 1'b0);
        repeat (100) @(negedge clk);
        #1;
        check("gap no writes", 32'(q_addr.size()), 32'd21);
        check("gap busy", 32'(busy), 32'd1);
        pulse(1'b0, 1'b1);
        wait_writes(64, 200, "gap resume done");
        @(negedge clk);
        check_fill("gap fill", 16'h001F);

        // Two frames while the window is closed: second one overruns.
        pulse(1'b1, 1'b0);
        clear_log();
        send_frame(24'h07_1111, 24);
        send_frame(24'h09_2222, 24);
        #1;
        check("overrun writes", 32'(q_addr.size()), 32'd0);
        check("overrun err", 32'(err_cnt), 32'd1);
        check("overrun busy", 32'(busy), 32'd1);
        pulse(1'b1, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        check("both pulses closed", 32'(q_addr.size()), 32'd0);
        pulse(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        check("overrun late writes", 32'(q_addr.size()), 32'd1);
        if (q_addr.size() > 0) begin
            check("overrun addr",  32'(q_addr[0]), 32'd7);
            check("overrun pixel", 32'(q_pix[0]),  32'h1111);
        end
        check("overrun busy after", 32'(busy), 32'd0);

        // Reset during a fill at address 30.
        clear_log();
        send_frame(24'h40_0AAA, 24);
        wait_writes(31, 200, "reset fill reach 30");
        n_at_reset = q_addr.size();
        reset = 1'b1;
        @(negedge clk);
        check("reset fill wr_en", 32'(ram_wr_en), 32'd0);
        check("reset fill busy",  32'(busy),      32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("reset fill no more writes", 32'(q_addr.size()), 32'(n_at_reset));
        check("reset fill stopped at 31", 32'(q_addr.size()), 32'd31);
        check("reset fill busy after", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wf_pixel_loader.md
WF_PIXEL_LOADER -- requirements
Module: wf_pixel_loader

Interface
REQ-001 clk  input  1  system clock, 12 MHz from SB_HFOSC; the only clock.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 ser_clk  input  1  asynchronous serial clock from CPU; data sampled on its rising edge.
REQ-004 ser_dat  input  1  asynchronous serial data from CPU, MSB first.
REQ-005 ser_cs_n  input  1  asynchronous frame select from CPU, active low.
REQ-006 scan_en  input  1  one-clk pulse, start of a display scan cycle (2 ms base).
REQ-007 scan_done  input  1  one-clk pulse, display driver finished shifting a row.
REQ-008 ram_wr_en  output  1  pixel RAM write strobe, registered.
REQ-009 ram_wr_addr  output  6  pixel RAM address {row[2:0],col[2:0]}, registered.
REQ-010 ram_wr_pixels  output  16  pixel word {1'b0,R[4:0],G[4:0],B[4:0]}, registered.
REQ-011 busy  output  1  high while a frame is pending or a fill is in progress.
REQ-012 frame_err  output  1  one-clk pulse on any rejected or malformed frame.

Function
REQ-013 ser_clk, ser_dat and ser_cs_n shall each pass through a two-flop synchronizer before use.
REQ-014 A bit shall be shifted in on each synchronized ser_clk rising edge while synchronized ser_cs_n is low; ser_clk high and low times are at least 3 clk periods.
REQ-015 A synchronized ser_cs_n falling edge shall clear the bit counter and shift register.
REQ-016 Frame is 24 bits: [23:22] opcode, [21:16] address, [15:0] pixel; pixel bit 15 shall always be written as 0.
REQ-017 On the 24th bit the frame shall be latched into a one-deep pending register on the next clk; further bits before ser_cs_n rises shall be ignored and shall pulse frame_err at the ser_cs_n rise, without cancelling the latched frame.
REQ-018 ser_cs_n rising with 1..23 bits received: frame discarded, frame_err pulses once.
REQ-019 A frame completing while the pending register is full (overrun): new frame dropped, frame_err pulses, pending frame unaffected.
REQ-020 Write window flag: cleared by scan_en, set by scan_done; scan_en wins on a simultaneous pulse.
REQ-021 ram_wr_en shall assert only while the window flag is high.
REQ-022 FSM states IDLE, WRITE, FILL.
REQ-023 IDLE: pending frame and window open -> decode opcode; 00 -> WRITE; 01 -> FILL with frame pixel; 10 -> FILL with 16'h0000; 11 -> frame_err pulse, pending cleared, remain IDLE.
REQ-024 WRITE: one cycle, ram_wr_en=1 at frame address, pending cleared, return to IDLE.
REQ-025 FILL: address counter 0..63, one write per clk while window open; window closed -> ram_wr_en=0, counter holds; after address 63 is written -> pending cleared, IDLE.
REQ-026 Latency: with window open, ram_wr_en shall assert exactly 2 clk after the clk detecting the 24th synchronized rising edge.
REQ-027 busy = pending register full OR state != IDLE; a new frame may be received during FILL.
REQ-028 ram_wr_addr/ram_wr_pixels hold their last values when ram_wr_en is low.

Reset
REQ-029 Reset shall force: state IDLE, pending empty, window flag low, bit counter 0, fill counter 0, ram_wr_en 0, ram_wr_addr 0, ram_wr_pixels 0, busy 0, frame_err 0.
REQ-030 Reset mid-frame or mid-fill shall abort; no write shall issue in the cycle after reset deasserts.
REQ-031 Synchronizer flops shall reset to the idle levels ser_clk=0, ser_cs_n=1.

Structure
REQ-032 Shared package wf_pixel_pkg: FRAME_BITS=24, opcodes OP_WRITE=2'b00, OP_FILL=2'b01, OP_CLEAR=2'b10, OP_RSVD=2'b11, state encodings.
REQ-033 One sub-module WF_serial_rx (synchronizers, edge detect, shift register, bit counter, frame_valid/frame_err outputs); FSM and window logic stay in the top.

Verification
REQ-034 Window open; frame 24'h05_7C1F (op 00, addr 5, pixel 7C1F) -> single write addr 5 data 16'h7C1F, 2 clk after 24th edge.
REQ-035 Frame 24'h40_03E0 (fill) with window open throughout -> 64 consecutive writes addr 0..63 data 16'h03E0, busy low after addr 63.
REQ-036 Fill with scan_en after address 20 and scan_done 100 clk later -> no writes during gap, resume at address 21, total 64 writes.
REQ-037 ser_cs_n raised after 10 bits -> frame_err one pulse, no write; frame 24'hC0_0000 -> frame_err, no write.
REQ-038 Two frames while window closed -> first written after scan_done, second dropped with frame_err; scan_en and scan_done same clk -> window stays closed.
REQ-039 Reset asserted at fill address 30 -> ram_wr_en low, busy low, no further writes.
